// File: rtl/luma_share_arb.sv
// Round-robin arbiter sharing one 2-stage RGB-to-luma pipeline between N_CH
// pixel sources; each result carries the ID of the channel it came from.
module luma_share_arb #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [24*N_CH-1:0]   req_data,
    output logic [N_CH-1:0]      req_ready,
    input  logic                 cfg_mode,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic [ID_W-1:0]      out_id,
    input  logic                 out_ready,
    output logic                 busy
);

    logic [ID_W-1:0] r_ptr;
    logic            r_s1Valid;
    logic [9:0]      r_s1Sum;
    logic [7:0]      r_s1Approx;
    logic            r_s1Mode;
    logic [ID_W-1:0] r_s1Id;
    logic            r_outValid;
    logic [7:0]      r_outData;
    logic [ID_W-1:0] r_outId;

    logic            w_en;
    logic            w_found;
    logic [ID_W-1:0] w_grantIdx;
    logic [N_CH-1:0] w_grant;
    logic            w_accept;
    logic [23:0]     w_selData;
    logic [7:0]      w_red;
    logic [7:0]      w_green;
    logic [7:0]      w_blue;
    logic [9:0]      w_sum;
    logic [8:0]      w_rg;
    logic [8:0]      w_mix;
    logic [7:0]      w_approx;
    logic [19:0]     w_prod;
    logic [7:0]      w_exact;

    assign w_en = !r_outValid || out_ready;

    // Search channels above the pointer first, then wrap to those at or below it.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        w_grant    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && req_valid[i] && (i > int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grantIdx = ID_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && req_valid[i] && (i <= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grantIdx = ID_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            w_grant[i] = w_found && w_en && !rst && (ID_W'(i) == w_grantIdx);
        end
    end

    assign w_accept = |w_grant;

    // The data mux is steered by the grant, so the grant never looks at pixel data.
    always_comb begin
        w_selData = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant[i]) begin
                w_selData = req_data[24*i +: 24];
            end
        end
    end

    assign w_red    = w_selData[7:0];
    assign w_green  = w_selData[15:8];
    assign w_blue   = w_selData[23:16];
    assign w_sum    = 10'(w_red) + 10'(w_green) + 10'(w_blue);
    assign w_rg     = 9'(w_red) + 9'(w_green);
    assign w_mix    = (w_rg >> 1) + 9'(w_blue);
    assign w_approx = 8'(w_mix >> 1);

    // 683/2048 slightly exceeds 1/3; the excess stays below 1/3 over 0..765, so the floor is exact.
    assign w_prod  = 20'(r_s1Sum) * 20'd683;
    assign w_exact = 8'(w_prod >> 11);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= ID_W'(N_CH - 1);
        end else if (w_accept) begin
            r_ptr <= w_grantIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Sum    <= '0;
            r_s1Approx <= '0;
            r_s1Mode   <= 1'b0;
            r_s1Id     <= '0;
        end else if (w_en) begin
            r_s1Valid  <= w_accept;
            r_s1Sum    <= w_sum;
            r_s1Approx <= w_approx;
            r_s1Mode   <= cfg_mode;
            r_s1Id     <= w_grantIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outId    <= '0;
        end else if (w_en) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outData <= r_s1Mode ? r_s1Approx : w_exact;
                r_outId   <= r_s1Id;
            end
        end
    end

    assign req_ready = w_grant;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_id    = r_outId;
    assign busy      = r_s1Valid || r_outValid;

endmodule
